// File: rtl/regarb_pkg.sv
// Shared state encoding and default widths for the register-unit arbiter.
package regarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } regarb_state_t;

  localparam int REGARB_ADDR_W   = 4;
  localparam int REGARB_DATA_W   = 8;
  localparam int REGARB_NUM_REGS = 16;

endpackage

// File: rtl/regarb_pick.sv
// Combinational winner picker: fixed lowest-index priority, or rotating priority
// starting after i_ptr when REGARB_ROUND_ROBIN_EN is defined.
module regarb_pick
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef REGARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
`ifdef REGARB_ROUND_ROBIN_EN
    // Walk the search order backwards so the first candidate after i_ptr wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
      end
    end
`endif
    if (|i_req) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the single-port register unit between NUM_REQ requesters (IDLE/ISSUE/WAIT/DONE).
// Arbitration policy is selected by REGARB_ROUND_ROBIN_EN (defined: rotating, else fixed).
module regfile_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REGARB_ADDR_W,
  parameter int DATA_W  = REGARB_DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0]   i_wdata_in,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_done,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_busy,
  output logic [ADDR_W-1:0]           o_rf_addr,
  output logic                        o_rf_load,
  output logic [DATA_W-1:0]           o_rf_wdata,
  input  logic [DATA_W-1:0]           i_rf_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  regarb_state_t       r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic                r_rf_load;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [NUM_REQ-1:0]  w_onehot;
  logic [IDX_W-1:0]    w_idx;
`ifdef REGARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    r_ptr;
`endif

  regarb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (i_req),
`ifdef REGARB_ROUND_ROBIN_EN
    .i_ptr    (r_ptr),
`endif
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_load  <= 1'b0;
      r_rf_wdata <= '0;
`ifdef REGARB_ROUND_ROBIN_EN
      r_ptr      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gnt      <= w_onehot;
            r_busy     <= 1'b1;
            r_rf_addr  <= i_addr_in[w_idx*ADDR_W +: ADDR_W];
            r_rf_wdata <= i_wdata_in[w_idx*DATA_W +: DATA_W];
            r_rf_load  <= i_we[w_idx];
`ifdef REGARB_ROUND_ROBIN_EN
            r_ptr      <= w_idx;
`endif
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          // The unit writes or captures on this edge; reads need one more edge.
          r_rf_load <= 1'b0;
          if (r_rf_load) begin
            r_done  <= r_gnt;
            r_state <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_rdata <= i_rf_rdata;
          r_done  <= r_gnt;
          r_state <= DONE;
        end
        DONE: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_rdata    = r_rdata;
  assign o_busy     = r_busy;
  assign o_rf_addr  = r_rf_addr;
  assign o_rf_load  = r_rf_load;
  assign o_rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter with a behavioural register unit and reference model.
module tb_regfile_arbiter;
  import regarb_pkg::*;

  localparam int NR = 2;
  localparam int AW = REGARB_ADDR_W;
  localparam int DW = REGARB_DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     we = '0;
  logic [NR*AW-1:0]  addr_in = '0;
  logic [NR*DW-1:0]  wdata_in = '0;
  logic [NR-1:0]     gnt, done;
  logic [DW-1:0]     rdata, rf_wdata;
  logic              busy, rf_load;
  logic [AW-1:0]     rf_addr;
  logic [DW-1:0]     rf_rdata = '0;

  regfile_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .i_req(req), .i_we(we), .i_addr_in(addr_in),
    .i_wdata_in(wdata_in), .o_gnt(gnt), .o_done(done), .o_rdata(rdata), .o_busy(busy),
    .o_rf_addr(rf_addr), .o_rf_load(rf_load), .o_rf_wdata(rf_wdata), .i_rf_rdata(rf_rdata)
  );

  always #5 clock = ~clock;

  // Single-port register unit with one-edge registered read.
  logic [DW-1:0] unit_mem [REGARB_NUM_REGS];
  initial for (int i = 0; i < REGARB_NUM_REGS; i++) unit_mem[i] = '0;
  always @(posedge clock) begin
    rf_rdata <= unit_mem[rf_addr];
    if (rf_load) unit_mem[rf_addr] <= rf_wdata;
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_mem [REGARB_NUM_REGS];
  logic [DW-1:0] m_rdata;
  int m_last;
  int n_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input int pend, input int last);
`ifdef REGARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NR; k++)
      if (((pend >> ((last + k) % NR)) & 1) != 0) return (last + k) % NR;
`else
    for (int i = 0; i < NR; i++)
      if (((pend >> i) & 1) != 0) return i;
`endif
    return -1;
  endfunction

  task automatic wait_done(output int who, output int cyc);
    who = -1; cyc = 0; n_load = 0;
    while (cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (rf_load) n_load++;
      if (done != '0) begin
        who = -2;
        for (int i = 0; i < NR; i++) if (done == NR'(1 << i)) who = i;
        break;
      end
    end
    if (who == -1) begin
      errors++; checks++;
      $display("FAIL wait_done: no done within 20 cycles");
    end
  endtask

  task automatic drive(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[r] = 1'b1; we[r] = w;
    addr_in[r*AW +: AW] = a;
    wdata_in[r*DW +: DW] = d;
  endtask

  // Completes bookkeeping for a finished transaction by requester r.
  task automatic retire(input int r);
    logic [AW-1:0] a;
    a = addr_in[r*AW +: AW];
    if (we[r]) begin
      check("write_rdata_held", 32'(rdata), 32'(m_rdata));
      m_mem[a] = wdata_in[r*DW +: DW];
    end else begin
      check("read_rdata", 32'(rdata), 32'(m_mem[a]));
      m_rdata = m_mem[a];
    end
    m_last = r;
    req[r] = 1'b0;
  endtask

  typedef struct {
    int r; logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] exp_rd; int lat;
  } vec_t;
  vec_t tbl [8];

  int who, cyc, pend, w_exp, saw_done;
  logic first;
  int exp_seq [4];

  initial begin
    for (int i = 0; i < REGARB_NUM_REGS; i++) m_mem[i] = '0;
    m_rdata = '0;
    m_last = NR - 1;

    tbl[0] = '{0, 1'b1, 4'd3,  8'hA5, 8'h00, 2};
    tbl[1] = '{1, 1'b0, 4'd3,  8'h00, 8'hA5, 3};
    tbl[2] = '{0, 1'b1, 4'd15, 8'hFF, 8'hA5, 2};
    tbl[3] = '{1, 1'b0, 4'd15, 8'h00, 8'hFF, 3};
    tbl[4] = '{0, 1'b1, 4'd0,  8'h00, 8'hFF, 2};
    tbl[5] = '{0, 1'b0, 4'd0,  8'h11, 8'h00, 3};
    tbl[6] = '{1, 1'b1, 4'd7,  8'h3C, 8'h00, 2};
    tbl[7] = '{0, 1'b0, 4'd7,  8'h00, 8'h3C, 3};

    repeat (2) @(negedge clock);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_load", 32'(rf_load), 0);
    check("rst_rf_addr", 32'(rf_addr), 0);
    check("rst_rf_wdata", 32'(rf_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    reset = 1'b0;
    @(negedge clock);

    // Directed single-requester table.
    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].r, tbl[t].w, tbl[t].a, tbl[t].d);
      wait_done(who, cyc);
      check("tbl_who", 32'(who), 32'(tbl[t].r));
      check("tbl_lat", 32'(cyc), 32'(tbl[t].lat));
      check("tbl_rdata", 32'(rdata), 32'(tbl[t].exp_rd));
      check("tbl_nload", 32'(n_load), tbl[t].w ? 1 : 0);
      check("tbl_rf_addr", 32'(rf_addr), 32'(tbl[t].a));
      retire(tbl[t].r);
      @(negedge clock);
      check("tbl_idle", 32'({busy, gnt, done}), 0);
    end

    // Two requesters reading continuously.
    drive(0, 1'b0, 4'd3, 8'h00);
    drive(1, 1'b0, 4'd15, 8'h00);
`ifdef REGARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    first = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_done(who, cyc);
      check("contend_who", 32'(who), 32'(exp_seq[g]));
      check("contend_lat", 32'(cyc), first ? 3 : 4);
      check("contend_rdata", 32'(rdata), g[0] == exp_seq[g][0] ? 32'(m_mem[exp_seq[g] == 0 ? 3 : 15]) : 32'(m_mem[exp_seq[g] == 0 ? 3 : 15]));
      m_rdata = rdata;
      m_last = who;
      first = 1'b0;
    end
    req[0] = 1'b0;
    wait_done(who, cyc);
    check("contend_after_drop", 32'(who), 1);
    check("contend_after_rdata", 32'(rdata), 32'(m_mem[15]));
    m_rdata = rdata; m_last = 1;
    req = '0;
    @(negedge clock);

    // Reset asserted while a read sits in WAIT.
    drive(1, 1'b0, 4'd3, 8'h00);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_reset_gnt", 32'(gnt), 0);
    check("mid_reset_busy", 32'(busy), 0);
    check("mid_reset_rdata", 32'(rdata), 0);
    req = '0;
    saw_done = 0;
    @(negedge clock);
    reset = 1'b0;
    m_rdata = '0; m_last = NR - 1;
    repeat (3) begin
      @(negedge clock);
      if (done != '0) saw_done++;
    end
    check("reset_no_done", 32'(saw_done), 0);
    drive(0, 1'b0, 4'd7, 8'h00);
    drive(1, 1'b0, 4'd0, 8'h00);
    wait_done(who, cyc);
    check("post_reset_who", 32'(who), 0);
    check("post_reset_lat", 32'(cyc), 3);
    retire(0);
    wait_done(who, cyc);
    check("post_reset_who2", 32'(who), 1);
    retire(1);
    @(negedge clock);

    // Randomized rounds against the reference model.
    for (int rnd = 0; rnd < 40; rnd++) begin
      pend = int'($urandom_range(1, (1 << NR) - 1));
      for (int r = 0; r < NR; r++)
        if (((pend >> r) & 1) != 0)
          drive(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, REGARB_NUM_REGS - 1)), DW'($urandom));
      first = 1'b1;
      while (pend != 0) begin
        w_exp = model_pick(pend, m_last);
        wait_done(who, cyc);
        check("rand_who", 32'(who), 32'(w_exp));
        check("rand_lat", 32'(cyc), 32'((we[w_exp] ? 2 : 3) + (first ? 0 : 1)));
        retire(w_exp);
        pend = pend & ~(1 << w_exp);
        first = 1'b0;
      end
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
